// File: rtl/alu_seq_if.sv
// Handshake and result bundle between the EX-stage sequencer and the ALU.
// The master side drives operands, the slave side (the ALU) returns results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;
  logic [3:0]       aluop;
  logic             out_valid;
  logic [WIDTH-1:0] outPort;
  logic             negF;
  logic             zerF;
  logic             oveF;
  logic             busy;

  modport master (
    output in_valid, portA, portB, aluop,
    input  in_ready, out_valid, outPort, negF, zerF, oveF, busy
  );

  modport slave (
    input  in_valid, portA, portB, aluop,
    output in_ready, out_valid, outPort, negF, zerF, oveF, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with iterative multiply/divide into HI/LO.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | ready; simple ops complete in one cycle, mul/div start here
//  RUN   | one shift-add / restoring-divide step per cycle
//  DONE  | last step, sign fix-up, write HI/LO, pulse out_valid
//
// The iteration counter runs 0..WIDTH-2 in RUN and reaches WIDTH-1 in
// DONE, whose step is folded into the final result.  This puts the result
// pulse WIDTH cycles after the simple-op pulse, with in_ready already high.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic [WIDTH-1:0]   accHi, accLo;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   aSave;
  logic               isDiv, negRes, negRem, divZero;

  logic               outValidReg, negReg, zerReg, oveReg;
  logic [WIDTH-1:0]   outReg;

  logic               accept, isLong, signedOp;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH-1:0]   addRes, subRes;
  logic [WIDTH-1:0]   simpleRes;
  logic               simpleOve;

  logic [WIDTH:0]     mulSum, remShift, remDiff;
  logic [WIDTH-1:0]   stepHi, stepLo;
  logic [2*WIDTH-1:0] prodRaw, prodFix;
  logic [WIDTH-1:0]   finHi, finLo;

  assign accept   = bus.in_valid && (state == IDLE);
  assign isLong   = (bus.aluop >= 4'd10) && (bus.aluop <= 4'd13);
  assign signedOp = (bus.aluop == 4'd10) || (bus.aluop == 4'd12);
  assign absA     = (signedOp && bus.portA[WIDTH-1]) ? -bus.portA : bus.portA;
  assign absB     = (signedOp && bus.portB[WIDTH-1]) ? -bus.portB : bus.portB;
  assign addRes   = bus.portA + bus.portB;
  assign subRes   = bus.portA - bus.portB;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = outValidReg;
  assign bus.outPort   = outReg;
  assign bus.negF      = negReg;
  assign bus.zerF      = zerReg;
  assign bus.oveF      = oveReg;

  // Single-cycle operations, including HI/LO reads as of the accept edge
  always_comb begin
    simpleRes = '0;
    simpleOve = 1'b0;
    case (bus.aluop)
      4'd0:  simpleRes = bus.portA & bus.portB;
      4'd1:  simpleRes = bus.portA | bus.portB;
      4'd2:  simpleRes = bus.portA ^ bus.portB;
      4'd3:  simpleRes = ~(bus.portA | bus.portB);
      4'd4:  simpleRes = bus.portA << bus.portB[SHAMT_W-1:0];
      4'd5:  simpleRes = bus.portA >> bus.portB[SHAMT_W-1:0];
      4'd6: begin
        simpleRes = addRes;
        simpleOve = (bus.portA[WIDTH-1] == bus.portB[WIDTH-1]) &&
                    (addRes[WIDTH-1] != bus.portA[WIDTH-1]);
      end
      4'd7: begin
        simpleRes = subRes;
        simpleOve = (bus.portA[WIDTH-1] != bus.portB[WIDTH-1]) &&
                    (subRes[WIDTH-1] != bus.portA[WIDTH-1]);
      end
      4'd8:  simpleRes = {{(WIDTH-1){1'b0}}, (bus.portA < bus.portB)};
      4'd9:  simpleRes = {{(WIDTH-1){1'b0}}, ($signed(bus.portA) < $signed(bus.portB))};
      4'd14: simpleRes = hiReg;
      4'd15: simpleRes = loReg;
      default: simpleRes = '0;
    endcase
  end

  // One multiply or divide iteration on the accumulator pair
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    remShift = {accHi, accLo[WIDTH-1]};
    remDiff  = remShift - {1'b0, opnd};
    stepHi   = mulSum[WIDTH:1];
    stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
    if (isDiv) begin
      if (!remDiff[WIDTH]) begin
        stepHi = remDiff[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = remShift[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final step plus sign fix-up; MIN/-1 falls out naturally as MIN
  always_comb begin
    prodRaw = {stepHi, stepLo};
    prodFix = negRes ? -prodRaw : prodRaw;
    finHi   = prodFix[2*WIDTH-1:WIDTH];
    finLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      if (divZero) begin
        finLo = '1;
        finHi = aSave;
      end else begin
        finLo = negRes ? -stepLo : stepLo;
        finHi = negRem ? -stepHi : stepHi;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && isLong) stateNext = RUN;
      RUN:     if (cnt == SHAMT_W'(WIDTH-2)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      accHi       <= '0;
      accLo       <= '0;
      opnd        <= '0;
      aSave       <= '0;
      isDiv       <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
      outValidReg <= 1'b0;
      outReg      <= '0;
      negReg      <= 1'b0;
      zerReg      <= 1'b0;
      oveReg      <= 1'b0;
    end else begin
      outValidReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (isLong) begin
              cnt     <= '0;
              accHi   <= '0;
              accLo   <= absA;
              opnd    <= absB;
              aSave   <= bus.portA;
              isDiv   <= bus.aluop[2];
              negRes  <= signedOp && (bus.portA[WIDTH-1] ^ bus.portB[WIDTH-1]);
              negRem  <= signedOp && bus.portA[WIDTH-1];
              divZero <= (bus.portB == '0);
            end else begin
              outValidReg <= 1'b1;
              outReg      <= simpleRes;
              negReg      <= simpleRes[WIDTH-1];
              zerReg      <= (simpleRes == '0);
              oveReg      <= simpleOve;
            end
          end
        end
        RUN: begin
          accHi <= stepHi;
          accLo <= stepLo;
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
          hiReg       <= finHi;
          loReg       <= finLo;
          outValidReg <= 1'b1;
          outReg      <= finLo;
          negReg      <= finLo[WIDTH-1];
          zerReg      <= (finLo == '0);
          oveReg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and an 8-bit instance, scoreboard queues
// filled at drive time and drained by per-instance output monitors.
module tb_alu_seq;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  typedef struct {
    logic [31:0] out;
    logic        ove;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        ove;
    string       name;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  vec_t vecs[$];

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: actual 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    nChecks++;
    nFails++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference: full-precision SV arithmetic, HI/LO tracked across ops
  task automatic model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] out, output logic ove);
    logic [31:0] s;
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    sa  = a;
    sb  = b;
    out = '0;
    ove = 1'b0;
    case (op)
      4'd0: out = a & b;
      4'd1: out = a | b;
      4'd2: out = a ^ b;
      4'd3: out = ~(a | b);
      4'd4: out = a << b[4:0];
      4'd5: out = a >> b[4:0];
      4'd6: begin s = a + b; out = s; ove = (a[31] == b[31]) && (s[31] != a[31]); end
      4'd7: begin s = a - b; out = s; ove = (a[31] != b[31]) && (s[31] != a[31]); end
      4'd8: out = (a < b) ? 32'd1 : 32'd0;
      4'd9: out = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: begin p = longint'(sa) * longint'(sb); {mHi, mLo} = p; out = mLo; end
      4'd11: begin pu = {32'h0, a} * {32'h0, b}; {mHi, mLo} = pu; out = mLo; end
      4'd12: begin
        if (b == 32'h0) begin mLo = '1; mHi = a; end
        else if (a == MIN32 && b == 32'hFFFF_FFFF) begin mLo = MIN32; mHi = '0; end
        else begin mLo = sa / sb; mHi = sa % sb; end
        out = mLo;
      end
      4'd13: begin
        if (b == 32'h0) begin mLo = '1; mHi = a; end
        else begin mLo = a / b; mHi = a % b; end
        out = mLo;
      end
      4'd14: out = mHi;
      default: out = mLo;
    endcase
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expOut, input logic expOve, input bit useModel,
                         input string name);
    int          n;
    logic [31:0] mOut;
    logic        mOve;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (bus32.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail({name, "_ready_timeout"}, "in_ready stayed low, required high within 200 cycles");
      return;
    end
    model32(op, a, b, mOut, mOve);
    e.out  = useModel ? mOut : expOut;
    e.ove  = useModel ? mOve : expOve;
    e.due  = cyc + 1 + ((op >= 4'd10 && op <= 4'd13) ? 32 : 0);
    e.name = name;
    q32.push_back(e);
    bus32.in_valid = 1'b1;
    bus32.aluop    = op;
    bus32.portA    = a;
    bus32.portB    = b;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expOut, input logic expOve, input string name);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus8.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail({name, "_ready_timeout"}, "in_ready stayed low, required high within 100 cycles");
      return;
    end
    e.out  = {24'h0, expOut};
    e.ove  = expOve;
    e.due  = cyc + 1 + ((op >= 4'd10 && op <= 4'd13) ? 8 : 0);
    e.name = name;
    q8.push_back(e);
    bus8.in_valid = 1'b1;
    bus8.aluop    = op;
    bus8.portA    = a;
    bus8.portB    = b;
  endtask

  task automatic idle();
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout", "results still outstanding after 300 cycles");
  endtask

  // Stray in_valid while busy: must be ignored and never produce a pulse
  task automatic pokeBusy32(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy_in_ready", 32'(bus32.in_ready), 32'd0);
      check("busy_flag", 32'(bus32.busy), 32'd1);
      bus32.in_valid = 1'b1;
      bus32.aluop    = 4'd6;
      bus32.portA    = $urandom;
      bus32.portB    = $urandom;
    end
  endtask

  // Output monitor, 32-bit instance
  always @(negedge clk) begin
    if (!rst && bus32.out_valid === 1'b1) begin
      if (q32.size() == 0) begin
        fail("unexpected_pulse32", $sformatf("out_valid=1 outPort=0x%08h, required no pulse", bus32.outPort));
      end else begin
        exp_t e;
        e = q32.pop_front();
        check({e.name, "_out"},   bus32.outPort, e.out);
        check({e.name, "_negF"},  32'(bus32.negF), 32'(e.out[31]));
        check({e.name, "_zerF"},  32'(bus32.zerF), 32'(e.out == 32'h0));
        check({e.name, "_oveF"},  32'(bus32.oveF), 32'(e.ove));
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Output monitor, 8-bit instance
  always @(negedge clk) begin
    if (!rst && bus8.out_valid === 1'b1) begin
      if (q8.size() == 0) begin
        fail("unexpected_pulse8", $sformatf("out_valid=1 outPort=0x%02h, required no pulse", bus8.outPort));
      end else begin
        exp_t e;
        e = q8.pop_front();
        check({e.name, "_out"},   32'(bus8.outPort), e.out);
        check({e.name, "_negF"},  32'(bus8.negF), 32'(e.out[7]));
        check({e.name, "_zerF"},  32'(bus8.zerF), 32'(e.out[7:0] == 8'h0));
        check({e.name, "_oveF"},  32'(bus8.oveF), 32'(e.ove));
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int   n;
    int   e0;
    logic [3:0]  op;
    logic [31:0] a, b;

    bus32.in_valid = 1'b0; bus32.aluop = '0; bus32.portA = '0; bus32.portB = '0;
    bus8.in_valid  = 1'b0; bus8.aluop  = '0; bus8.portA  = '0; bus8.portB  = '0;

    vecs.push_back('{4'd6,  32'h7D2B7500, 32'h7D2B7500, 32'hFA56EA00, 1'b1, "add_ovf"});
    vecs.push_back('{4'd7,  32'd50,       32'd50,       32'h00000000, 1'b0, "sub_zero"});
    vecs.push_back('{4'd9,  32'hFFFFFFF6, 32'd67,       32'h00000001, 1'b0, "slt_neg"});
    vecs.push_back('{4'd8,  32'hFFFFFFF6, 32'd67,       32'h00000000, 1'b0, "sltu_neg"});
    vecs.push_back('{4'd4,  32'd75,       32'd33,       32'd150,      1'b0, "lsl_wrap_shamt"});
    vecs.push_back('{4'd5,  32'hFFFFFFFC, 32'd2,        32'h3FFFFFFF, 1'b0, "lsr"});
    vecs.push_back('{4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, "and"});
    vecs.push_back('{4'd1,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, "or"});
    vecs.push_back('{4'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, "xor"});
    vecs.push_back('{4'd3,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, "nor"});
    vecs.push_back('{4'd7,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, "sub_ovf"});
    vecs.push_back('{4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, "add_wrap_zero"});
    vecs.push_back('{4'd10, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0, "mult_neg"});
    vecs.push_back('{4'd14, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, "mult_neg_hi"});
    vecs.push_back('{4'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_neg"});
    vecs.push_back('{4'd14, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, "div_neg_hi"});
    vecs.push_back('{4'd13, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, "divu_zero"});
    vecs.push_back('{4'd14, 32'h0,        32'h0,        32'd9,        1'b0, "divu_zero_hi"});
    vecs.push_back('{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_min"});
    vecs.push_back('{4'd14, 32'h0,        32'h0,        32'h00000000, 1'b0, "div_min_hi"});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus32.in_ready), 32'd1);
    check("rst_busy",      32'(bus32.busy), 32'd0);
    check("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    check("rst_outPort",   bus32.outPort, 32'h0);
    check("rst_negF",      32'(bus32.negF), 32'd0);
    check("rst_zerF",      32'(bus32.zerF), 32'd0);
    check("rst_oveF",      32'(bus32.oveF), 32'd0);
    check("rst8_in_ready", 32'(bus8.in_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      issue32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].ove, 1'b0, vecs[i].name);

    issue32(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "multu_max");
    pokeBusy32(5);
    issue32(4'd14, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, "multu_max_hi");
    issue32(4'd15, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b0, "multu_max_lo");

    for (int i = 0; i < 16; i++) begin
      op = 4'(10 + $urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue32(op, a, b, 32'h0, 1'b0, 1'b1, "rand_muldiv");
      issue32(4'd14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "rand_mfhi");
    end
    idle();
    drain();

    // Reset in the middle of a divide
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.aluop    = 4'd12;
    bus32.portA    = 32'hFFFFFFF9;
    bus32.portB    = 32'd2;
    e0 = cyc + 1;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    n = 0;
    while (cyc < e0 + 9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_div_busy", 32'(bus32.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("after_rst_in_ready",  32'(bus32.in_ready), 32'd1);
    check("after_rst_busy",      32'(bus32.busy), 32'd0);
    check("after_rst_out_valid", 32'(bus32.out_valid), 32'd0);
    mHi = '0;
    mLo = '0;
    repeat (40) @(negedge clk);
    issue32(4'd15, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "after_rst_mflo");
    issue32(4'd14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, "after_rst_mfhi");
    idle();
    drain();

    issue8(4'd6,  8'h7F, 8'h01, 8'h80, 1'b1, "w8_add_ovf");
    issue8(4'd4,  8'h03, 8'h09, 8'h06, 1'b0, "w8_lsl_wrap_shamt");
    issue8(4'd11, 8'hFF, 8'hFF, 8'h01, 1'b0, "w8_multu");
    issue8(4'd14, 8'h00, 8'h00, 8'hFE, 1'b0, "w8_multu_hi");
    issue8(4'd10, 8'hFD, 8'h07, 8'hEB, 1'b0, "w8_mult_neg");
    issue8(4'd14, 8'h00, 8'h00, 8'hFF, 1'b0, "w8_mult_neg_hi");
    issue8(4'd12, 8'hF9, 8'h02, 8'hFD, 1'b0, "w8_div_neg");
    issue8(4'd14, 8'h00, 8'h00, 8'hFF, 1'b0, "w8_div_neg_hi");
    issue8(4'd12, 8'h80, 8'hFF, 8'h80, 1'b0, "w8_div_min");
    issue8(4'd14, 8'h00, 8'h00, 8'h00, 1'b0, "w8_div_min_hi");
    issue8(4'd13, 8'h09, 8'h00, 8'hFF, 1'b0, "w8_divu_zero");
    issue8(4'd14, 8'h00, 8'h00, 8'h09, 1'b0, "w8_divu_zero_hi");
    idle();
    drain();

    repeat (5) @(negedge clk);
    check("q32_empty", 32'(q32.size()), 32'd0);
    check("q8_empty",  32'(q8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
